// File: rtl/rvee_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : rvee_regfile
//  Desc     : Architectural integer register file for the rvee core. Two
//             registered read ports and one commit write port, with optional
//             forwarding of the in-flight exec result (mem_*) and of the
//             same-edge commit (wb_*) into the read ports.
//  Options  : `define RVEE_RF_BYPASS_EN to enable forwarding. Without it the
//             read ports return only pre-edge array contents and mem_* are
//             ignored.
//  Revision : 1.0  initial release
// ============================================================================
module rvee_regfile #(
    parameter int N_REGS = 32,
    parameter int XLEN   = 32,
    localparam int AW    = $clog2(N_REGS)
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active-low
    input  logic            rd_en,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data
);

    // Flat view of the architectural state; entry 0 is the hard-wired zero
    // register and has no storage behind it.
    logic [N_REGS-1:0][XLEN-1:0] view;
    logic [XLEN-1:0]             rs1_next;
    logic [XLEN-1:0]             rs2_next;

    assign view[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < N_REGS; gi++) begin : g_reg
            logic [XLEN-1:0] q;

            // One architectural register; x0 is never generated so writes
            // to index 0 fall through without effect.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q <= '0;
                end else if (wb_we && (wb_rd == AW'(gi))) begin
                    q <= wb_data;
                end
            end

            assign view[gi] = q;
        end
    endgenerate

`ifdef RVEE_RF_BYPASS_EN
    // Operand selection; later assignments override earlier ones, so the
    // order below is lowest to highest priority: array, commit, in-flight, x0.
    always_comb begin
        rs1_next = view[rs1];
        rs2_next = view[rs2];
        if (wb_we && (wb_rd == rs1)) begin
            rs1_next = wb_data;
        end
        if (wb_we && (wb_rd == rs2)) begin
            rs2_next = wb_data;
        end
        if (mem_we && (mem_rd == rs1)) begin
            rs1_next = mem_data;
        end
        if (mem_we && (mem_rd == rs2)) begin
            rs2_next = mem_data;
        end
        if (rs1 == '0) begin
            rs1_next = '0;
        end
        if (rs2 == '0) begin
            rs2_next = '0;
        end
    end
`else
    // The in-flight result has no consumer when forwarding is disabled.
    logic unused_ok;
    assign unused_ok = ^{mem_we, mem_rd, mem_data};

    // Operand selection straight from pre-edge array contents (view[0] is 0).
    always_comb begin
        rs1_next = view[rs1];
        rs2_next = view[rs2];
    end
`endif

    // Read-port output registers; they hold while decode is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_data <= '0;
            rs2_data <= '0;
        end else if (rd_en) begin
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvee_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvee_regfile
//  Desc     : Self-checking bench for rvee_regfile. Drives a 32-entry and a
//             16-entry instance with the same stimulus (indices truncated for
//             the small one) and compares both against an array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rvee_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [4:0]  rs1, rs2, wb_rd, mem_rd;
    logic        wb_we, mem_we;
    logic [31:0] wb_data, mem_data;

    logic [31:0] rs1_data32, rs2_data32, rs1_data16, rs2_data16;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state and expected outputs
    logic [31:0] m32 [32];
    logic [31:0] m16 [16];
    logic [31:0] e32_1, e32_2, e16_1, e16_2;

    always #5 clk = ~clk;

    rvee_regfile #(.N_REGS(32), .XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .rd_en(rd_en),
        .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data32), .rs2_data(rs2_data32),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data)
    );

    rvee_regfile #(.N_REGS(16), .XLEN(32)) dut16 (
        .clk(clk), .rst(rst), .rd_en(rd_en),
        .rs1(rs1[3:0]), .rs2(rs2[3:0]),
        .rs1_data(rs1_data16), .rs2_data(rs2_data16),
        .wb_we(wb_we), .wb_rd(wb_rd[3:0]), .wb_data(wb_data),
        .mem_we(mem_we), .mem_rd(mem_rd[3:0]), .mem_data(mem_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Value a read port should capture for a 32-entry file.
    function automatic logic [31:0] pick32(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef RVEE_RF_BYPASS_EN
        if (mem_we && mem_rd == idx) return mem_data;
        if (wb_we && wb_rd == idx) return wb_data;
`endif
        return m32[idx];
    endfunction

    // Same rules for the 16-entry file, which sees 4-bit indices.
    function automatic logic [31:0] pick16(input logic [3:0] idx);
        if (idx == 4'd0) return 32'd0;
`ifdef RVEE_RF_BYPASS_EN
        if (mem_we && mem_rd[3:0] == idx) return mem_data;
        if (wb_we && wb_rd[3:0] == idx) return wb_data;
`endif
        return m16[idx];
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_rs1_32"}, rs1_data32, e32_1);
        check({tag, "_rs2_32"}, rs2_data32, e32_2);
        check({tag, "_rs1_16"}, rs1_data16, e16_1);
        check({tag, "_rs2_16"}, rs2_data16, e16_2);
    endtask

    // One clock: predict, clock, update the model, compare.
    task automatic cycle(input string tag);
        logic [3:0] w16;
        w16 = wb_rd[3:0];
        if (rd_en) begin
            e32_1 = pick32(rs1);
            e32_2 = pick32(rs2);
            e16_1 = pick16(rs1[3:0]);
            e16_2 = pick16(rs2[3:0]);
        end
        @(posedge clk);
        if (wb_we && wb_rd != 5'd0) m32[wb_rd] = wb_data;
        if (wb_we && w16 != 4'd0)   m16[w16]   = wb_data;
        #1;
        check_all(tag);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m32[i] = 32'd0;
        for (int i = 0; i < 16; i++) m16[i] = 32'd0;
        e32_1 = 0; e32_2 = 0; e16_1 = 0; e16_2 = 0;
    endtask

    task automatic idle();
        rd_en = 1'b1; wb_we = 1'b0; mem_we = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        wb_we = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rd_en = 1'b0; rs1 = 0; rs2 = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0;
        mem_we = 0; mem_rd = 0; mem_data = 0;
        clear_model();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Write x5 then read it back on both ports
        idle(); wb(5'd5, 32'h1234); cycle("wr_x5");
        idle(); rs1 = 5; rs2 = 5;   cycle("rd_x5");
        check("x5_const", rs1_data32, 32'h1234);

        // Asynchronous reset in the middle of a cycle
        wb(5'd6, 32'h6666);
        #2 rst = 1'b0;
        #1;
        clear_model();
        check_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        idle(); rs1 = 5; rs2 = 6; cycle("post_rst");
        check("x5_after_rst", rs1_data32, 32'h0);

        // Write then read, and x0 stays zero
        idle(); wb(5'd7, 32'hDEADBEEF); rs1 = 0; cycle("wr_x7");
        idle(); rs1 = 7; rs2 = 0;       cycle("rd_x7");
        check("x7_const", rs1_data32, 32'hDEADBEEF);
        idle(); wb(5'd0, 32'hFFFFFFFF); cycle("wr_x0");
        idle(); rs1 = 0; rs2 = 0;       cycle("rd_x0");
        check("x0_const", rs1_data32, 32'h0);

        // mem vs wb priority on the same index
        idle(); wb(5'd3, 32'h11); cycle("wr_x3");
        idle(); wb(5'd3, 32'h22); mem_we = 1; mem_rd = 3; mem_data = 32'h33;
        rs1 = 3; rs2 = 3; cycle("prio");
`ifdef RVEE_RF_BYPASS_EN
        check("prio_const", rs2_data32, 32'h33);
`else
        check("prio_const", rs2_data32, 32'h11);
`endif
        idle(); cycle("prio_next");
        check("prio_next_const", rs1_data32, 32'h22);

        // Write-through of a same-edge commit
        idle(); wb(5'd9, 32'h77); cycle("wr_x9_old");
        idle(); wb(5'd9, 32'hA5A5A5A5); rs2 = 9; cycle("wt");
`ifdef RVEE_RF_BYPASS_EN
        check("wt_const", rs2_data32, 32'hA5A5A5A5);
`else
        check("wt_const", rs2_data32, 32'h77);
`endif
        idle(); cycle("wt_next");
        check("wt_next_const", rs2_data32, 32'hA5A5A5A5);

        // Hold while decode is stalled; commits still land
        idle(); rs1 = 7; cycle("pre_hold");
        rd_en = 0; wb(5'd1, 32'h55); rs1 = 1;  cycle("hold1");
        rd_en = 0; wb_we = 0; rs1 = 9;         cycle("hold2");
        rd_en = 0; rs1 = 3;                    cycle("hold3");
        check("hold_const", rs1_data32, 32'hDEADBEEF);
        idle(); rs1 = 1; cycle("after_hold");
        check("x1_const", rs1_data32, 32'h55);

        // Top entry of each file (x15 is the last register of the small one)
        idle(); wb(5'd15, 32'hCAFE); cycle("wr_x15");
        idle(); rs1 = 15; rs2 = 31; cycle("rd_x15");
        check("x15_const16", rs1_data16, 32'hCAFE);

        // Random traffic, biased toward low indices so hazards actually occur
        for (int n = 0; n < 400; n++) begin
            logic hot;
            hot      = ($urandom_range(0, 1) == 1);
            rd_en    = ($urandom_range(0, 7) != 0);
            rs1      = hot ? 5'($urandom_range(0, 5)) : 5'($urandom);
            rs2      = hot ? 5'($urandom_range(0, 5)) : 5'($urandom);
            wb_we    = ($urandom_range(0, 3) != 0);
            wb_rd    = hot ? 5'($urandom_range(0, 5)) : 5'($urandom);
            wb_data  = $urandom;
            mem_we   = ($urandom_range(0, 1) == 1);
            mem_rd   = hot ? 5'($urandom_range(0, 5)) : 5'($urandom);
            mem_data = $urandom;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvee_regfile.md
# rvee_regfile

Architectural integer register file for the rvee core, with pipeline bypass. Sits between decode (read side) and the exec/mem stages (bypass and write side). Decode presents source indices; operands return one cycle later through registered read ports. Results in flight from exec and mem are forwarded so decode sees the newest value without a stall.

## Interface
- N_REGS, 32, number of architectural registers (32 for RV32I, 16 for RV32E); power of two, ≥ 2
- XLEN, 32, register width in bits
- AW (local), $clog2(N_REGS), index width

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk by the system)
- rd_en  in  1  decode advancing; when 0 the read-port output registers hold
- rs1  in  AW  source index 1
- rs2  in  AW  source index 2
- rs1_data  out  XLEN  operand 1, registered
- rs2_data  out  XLEN  operand 2, registered
- wb_we  in  1  commit write enable from mem stage
- wb_rd  in  AW  commit destination
- wb_data  in  XLEN  commit value
- mem_we  in  1  exec result in flight (valid, will commit later)
- mem_rd  in  AW  in-flight destination
- mem_data  in  XLEN  in-flight value

## Operation
- Storage: registers x1..x(N_REGS-1), XLEN bits each; x0 has no storage and always reads 0.
- Write: on a rising edge with wb_we=1 and wb_rd≠0, reg[wb_rd] ← wb_data. Writes to x0 are dropped. mem_* never writes the array.
- Read (per port p ∈ {1,2}, independent): on a rising edge with rd_en=1, rsp_data ← the selected value, in priority order:
  1. rsp=0 → 0
  2. mem_we=1 and mem_rd=rsp → mem_data
  3. wb_we=1 and wb_rd=rsp → wb_data (write-through of the same-edge commit)
  4. otherwise → reg[rsp] (pre-edge contents)
- rd_en=0: rs1_data/rs2_data hold. Array writes still occur.
- Both ports may select the same index, and any source may match both ports. Each port resolves independently.
- mem and wb targeting the same rd on the same edge: mem wins on reads; the array takes wb_data.
- Indices ≥ N_REGS cannot occur (AW-wide); no range check.

## Timing
- Read latency: 1 cycle (index at edge n → data valid after edge n, usable in cycle n+1).
- Write latency: a value written at edge n appears in array reads at edge n+1; it is bypassed at edge n.
- Reset (rst=0, asynchronous): all array registers → 0; rs1_data → 0; rs2_data → 0. Reset mid-operation discards any same-edge write.
- No combinational path from inputs to outputs.

## Configuration
- RVEE_RF_BYPASS_EN defined: priority rules 2 and 3 are active, as above.
- Not defined: reads return 0 for x0, otherwise reg[rsp] pre-edge only; mem_* are ignored, and there is no write-through. The hazard unit must stall decode until the commit has been written. Port list is unchanged.

## Test plan
- Reset: drive rst=0 mid-run with x5 holding 0x1234 → rs1_data=rs2_data=0 immediately; after release, reading x5 returns 0.
- Write then read: wb_we=1, wb_rd=7, wb_data=0xDEADBEEF at edge n; rs1=7 at edge n+1 → rs1_data=0xDEADBEEF. Writing x0=0xFFFFFFFF then reading x0 → 0.
- Bypass priority (BYPASS_EN): x3=0x11 in the array; same edge mem_we=1/mem_rd=3/0x33 and wb_we=1/wb_rd=3/0x22, rs1=rs2=3 → both ports read 0x33; next edge with mem_we=0 → 0x22.
- Write-through: wb writes x9=0xA5A5A5A5 while rs2=9 on the same edge → rs2_data=0xA5A5A5A5 with BYPASS_EN; without the macro → old x9 value, then 0xA5A5A5A5 one edge later.
- Hold: rd_en=0 for 3 cycles while rs1 changes and wb writes x1=0x55 → rs1_data stays constant. rd_en=1 with rs1=1 → 0x55.
- Parameterisation: N_REGS=16 (AW=4): write x15=0xCAFE, read x15 → 0xCAFE; random write/read sequences match a reference model on both ports.
